// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states, default width.
// MULDIV_ITER_MUL_EN adds the MUL_RUN state used by the iterative multiplier build.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
`ifdef MULDIV_ITER_MUL_EN
    S_MUL_RUN = 2'd1,
`endif
    S_DIV_RUN = 2'd2,
    S_FINISH  = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_if.sv
// Decoder-facing request bus and HI/LO result bus of the multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = muldiv_pkg::DEFAULT_WIDTH);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_div_core.sv
// Restoring radix-2 divider on unsigned magnitudes: one quotient bit per cycle for WIDTH cycles.
// done is high during the final iteration; quotient/remainder are valid from the following cycle.
module div_core #(
  parameter int WIDTH = muldiv_pkg::DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic             running;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo, rem, dsr;
  logic [WIDTH:0]   trial, diff;

  // Shift the next dividend bit into the partial remainder and try subtracting the divisor.
  assign trial = {rem, quo[WIDTH-1]};
  assign diff  = trial - {1'b0, dsr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dsr     <= '0;
    end else if (clear) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= CNT_W'(WIDTH - 1);
      quo     <= dividend;
      rem     <= '0;
      dsr     <= divisor;
    end else if (running) begin
      quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
      rem <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
      if (cnt == '0) running <= 1'b0;
      else           cnt     <= cnt - 1'b1;
    end
  end

  assign done      = running && (cnt == '0);
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/muldiv_unit.sv
// Execute-stage multiply/divide unit owning HI/LO; stalls the pipeline through busy while iterating.
// Define MULDIV_ITER_MUL_EN for a WIDTH-cycle shift-add multiplier instead of the one-cycle multiply.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  md_state_e        state, state_next;
  logic [WIDTH-1:0] hi_q, lo_q, hi_next, lo_next, saved_a;
  logic [WIDTH-1:0] mag_a, mag_b, quotient, remainder;
  logic             wr_hi, wr_lo, idle_wr, done_q;
  logic             neg_q, neg_r, dbz, is_signed, accept;
  logic             div_start, div_done;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  assign accept    = bus.start && !bus.flush && (state == S_IDLE);
  assign is_signed = (bus.op == MD_MULT) || (bus.op == MD_DIV);
  assign mag_a     = mag(bus.a, is_signed);
  assign mag_b     = mag(bus.b, is_signed);

  div_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .clear    (bus.flush),
    .start    (div_start),
    .dividend (mag_a),
    .divisor  (mag_b),
    .done     (div_done),
    .quotient (quotient),
    .remainder(remainder)
  );

`ifdef MULDIV_ITER_MUL_EN
  logic [2*WIDTH:0] mul_p;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_a;
  logic [CNT_W-1:0] mul_cnt;
  logic             mul_start, is_mul;

  // Accumulate the multiplicand into the upper half when the current multiplier bit is set, then shift right.
  assign mul_sum = mul_p[2*WIDTH:WIDTH] + (mul_p[0] ? {1'b0, mul_a} : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_p   <= '0;
      mul_a   <= '0;
      mul_cnt <= '0;
      is_mul  <= 1'b0;
    end else begin
      if (accept) is_mul <= (bus.op == MD_MULT) || (bus.op == MD_MULTU);
      if (mul_start) begin
        mul_p   <= {{(WIDTH+1){1'b0}}, mag_b};
        mul_a   <= mag_a;
        mul_cnt <= CNT_W'(WIDTH - 1);
      end else if (state == S_MUL_RUN) begin
        mul_p <= {1'b0, mul_sum, mul_p[WIDTH-1:1]};
        if (mul_cnt != '0) mul_cnt <= mul_cnt - 1'b1;
      end
    end
  end
`else
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;

  // Sign-extending to 2*WIDTH makes the truncated unsigned product correct for both signednesses.
  assign ext_a = is_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
  assign ext_b = is_signed ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
  assign prod  = ext_a * ext_b;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dbz     <= 1'b0;
      saved_a <= '0;
    end else begin
      state  <= state_next;
      done_q <= idle_wr;
      if (wr_hi) hi_q <= hi_next;
      if (wr_lo) lo_q <= lo_next;
      if (accept) begin
        neg_q   <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        neg_r   <= is_signed && bus.a[WIDTH-1];
        dbz     <= (bus.b == '0);
        saved_a <= bus.a;
      end
    end
  end

  always_comb begin
    state_next = state;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    hi_next    = hi_q;
    lo_next    = lo_q;
    idle_wr    = 1'b0;
    div_start  = 1'b0;
`ifdef MULDIV_ITER_MUL_EN
    mul_start  = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          case (bus.op)
            MD_MULT, MD_MULTU: begin
`ifdef MULDIV_ITER_MUL_EN
              mul_start  = 1'b1;
              state_next = S_MUL_RUN;
`else
              {hi_next, lo_next} = prod;
              wr_hi   = 1'b1;
              wr_lo   = 1'b1;
              idle_wr = 1'b1;
`endif
            end
            MD_DIV, MD_DIVU: begin
              div_start  = 1'b1;
              state_next = S_DIV_RUN;
            end
            MD_MTHI: begin
              hi_next = bus.a;
              wr_hi   = 1'b1;
              idle_wr = 1'b1;
            end
            MD_MTLO: begin
              lo_next = bus.a;
              wr_lo   = 1'b1;
              idle_wr = 1'b1;
            end
            default: ;
          endcase
        end
      end
`ifdef MULDIV_ITER_MUL_EN
      S_MUL_RUN: if (mul_cnt == '0) state_next = S_FINISH;
`endif
      S_DIV_RUN: if (div_done) state_next = S_FINISH;
      S_FINISH: begin
        state_next = S_IDLE;
        wr_hi      = 1'b1;
        wr_lo      = 1'b1;
`ifdef MULDIV_ITER_MUL_EN
        if (is_mul)
          {hi_next, lo_next} = neg_q ? -mul_p[2*WIDTH-1:0] : mul_p[2*WIDTH-1:0];
        else
`endif
        if (dbz) begin
          hi_next = saved_a;
          lo_next = '1;
        end else begin
          lo_next = neg_q ? -quotient : quotient;
          hi_next = neg_r ? -remainder : remainder;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // A flush aborts whatever is in flight and suppresses every register write.
    if (bus.flush) begin
      state_next = S_IDLE;
      wr_hi      = 1'b0;
      wr_lo      = 1'b0;
      idle_wr    = 1'b0;
      div_start  = 1'b0;
`ifdef MULDIV_ITER_MUL_EN
      mul_start  = 1'b0;
`endif
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state != S_IDLE);
  assign bus.done = !bus.flush && (done_q || (state == S_FINISH));

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; expectations are hand-computed for WIDTH=32.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Counts busy cycles from the current one until busy falls, noting where done appeared (bounded).
  task automatic wait_idle(output int nbusy, output int ndone, output int done_at);
    nbusy   = 0;
    ndone   = 0;
    done_at = -1;
    for (int i = 0; i < 200 && bus.busy; i++) begin
      nbusy++;
      if (bus.done) begin
        ndone++;
        done_at = nbusy;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    rst       = 1'b1;
    #2;
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h want %h", bus.hi, 32'h0); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h want %h", bus.lo, 32'h0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", bus.done); end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    int nb, nd, da;
`ifdef MULDIV_ITER_MUL_EN
    issue(MD_MULT, 32'hFFFFFFFE, 32'h00000003);
    wait_idle(nb, nd, da);
    checks++; if (nb !== 33) begin errors++; $display("[TB] FAIL mult_busy_cycles: got %0d want 33", nb); end
    checks++; if (da !== 33) begin errors++; $display("[TB] FAIL mult_done_at: got %0d want 33", da); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h want %h", bus.hi, 32'hFFFFFFFF); end
    checks++; if (bus.lo !== 32'hFFFFFFFA) begin errors++; $display("[TB] FAIL mult_lo: got %h want %h", bus.lo, 32'hFFFFFFFA); end
    issue(MD_MULTU, 32'hFFFFFFFE, 32'h00000003);
    wait_idle(nb, nd, da);
    checks++; if (bus.hi !== 32'h00000002) begin errors++; $display("[TB] FAIL multu_hi: got %h want %h", bus.hi, 32'h2); end
    checks++; if (bus.lo !== 32'hFFFFFFFA) begin errors++; $display("[TB] FAIL multu_lo: got %h want %h", bus.lo, 32'hFFFFFFFA); end
    issue(MD_MULT, 32'h00010000, 32'h00010000);
    wait_idle(nb, nd, da);
    checks++; if (nb !== 33) begin errors++; $display("[TB] FAIL mult_big_busy: got %0d want 33", nb); end
    checks++; if (bus.hi !== 32'h00000001) begin errors++; $display("[TB] FAIL mult_big_hi: got %h want %h", bus.hi, 32'h1); end
    checks++; if (bus.lo !== 32'h00000000) begin errors++; $display("[TB] FAIL mult_big_lo: got %h want %h", bus.lo, 32'h0); end
`else
    issue(MD_MULT, 32'hFFFFFFFE, 32'h00000003);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL mult_done: got %b want 1", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL mult_busy: got %b want 0", bus.busy); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h want %h", bus.hi, 32'hFFFFFFFF); end
    checks++; if (bus.lo !== 32'hFFFFFFFA) begin errors++; $display("[TB] FAIL mult_lo: got %h want %h", bus.lo, 32'hFFFFFFFA); end
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL mult_done_pulse: got %b want 0", bus.done); end
    issue(MD_MULTU, 32'hFFFFFFFE, 32'h00000003);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL multu_done: got %b want 1", bus.done); end
    checks++; if (bus.hi !== 32'h00000002) begin errors++; $display("[TB] FAIL multu_hi: got %h want %h", bus.hi, 32'h2); end
    checks++; if (bus.lo !== 32'hFFFFFFFA) begin errors++; $display("[TB] FAIL multu_lo: got %h want %h", bus.lo, 32'hFFFFFFFA); end
    tick();
`endif
  endtask

  task automatic test_div();
    int nb, nd, da;
    issue(MD_DIV, 32'hFFFFFFF9, 32'h00000002);
    wait_idle(nb, nd, da);
    checks++; if (nb !== 33) begin errors++; $display("[TB] FAIL div_busy_cycles: got %0d want 33", nb); end
    checks++; if (nd !== 1) begin errors++; $display("[TB] FAIL div_done_count: got %0d want 1", nd); end
    checks++; if (da !== 33) begin errors++; $display("[TB] FAIL div_done_at: got %0d want 33", da); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL div_done_after: got %b want 0", bus.done); end
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_lo: got %h want %h", bus.lo, 32'hFFFFFFFD); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div_hi: got %h want %h", bus.hi, 32'hFFFFFFFF); end
    issue(MD_DIVU, 32'h00000007, 32'h00000002);
    wait_idle(nb, nd, da);
    checks++; if (bus.lo !== 32'h00000003) begin errors++; $display("[TB] FAIL divu_lo: got %h want %h", bus.lo, 32'h3); end
    checks++; if (bus.hi !== 32'h00000001) begin errors++; $display("[TB] FAIL divu_hi: got %h want %h", bus.hi, 32'h1); end
  endtask

  task automatic test_boundary();
    int nb, nd, da;
    issue(MD_DIVU, 32'h12345678, 32'h00000000);
    wait_idle(nb, nd, da);
    checks++; if (nb !== 33) begin errors++; $display("[TB] FAIL dbz_busy_cycles: got %0d want 33", nb); end
    checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL dbz_u_lo: got %h want %h", bus.lo, 32'hFFFFFFFF); end
    checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("[TB] FAIL dbz_u_hi: got %h want %h", bus.hi, 32'h12345678); end
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(nb, nd, da);
    checks++; if (bus.lo !== 32'h80000000) begin errors++; $display("[TB] FAIL ovf_lo: got %h want %h", bus.lo, 32'h80000000); end
    checks++; if (bus.hi !== 32'h00000000) begin errors++; $display("[TB] FAIL ovf_hi: got %h want %h", bus.hi, 32'h0); end
    issue(MD_DIV, 32'hFFFFFFF9, 32'h00000000);
    wait_idle(nb, nd, da);
    checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL dbz_s_lo: got %h want %h", bus.lo, 32'hFFFFFFFF); end
    checks++; if (bus.hi !== 32'hFFFFFFF9) begin errors++; $display("[TB] FAIL dbz_s_hi: got %h want %h", bus.hi, 32'hFFFFFFF9); end
    issue(MD_DIV, 32'h00000007, 32'hFFFFFFFE);
    wait_idle(nb, nd, da);
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_negb_lo: got %h want %h", bus.lo, 32'hFFFFFFFD); end
    checks++; if (bus.hi !== 32'h00000001) begin errors++; $display("[TB] FAIL div_negb_hi: got %h want %h", bus.hi, 32'h1); end
  endtask

  task automatic test_back_to_back();
    int nb, nd, da;
    issue(MD_DIVU, 32'd100, 32'd7);
    tick();
    tick();
    issue(MD_DIVU, 32'd7, 32'd2);
    wait_idle(nb, nd, da);
    checks++; if (nb + 3 !== 33) begin errors++; $display("[TB] FAIL b2b_busy_cycles: got %0d want 33", nb + 3); end
    checks++; if (bus.lo !== 32'd14) begin errors++; $display("[TB] FAIL b2b_lo: got %h want %h", bus.lo, 32'd14); end
    checks++; if (bus.hi !== 32'd2) begin errors++; $display("[TB] FAIL b2b_hi: got %h want %h", bus.hi, 32'd2); end
  endtask

  task automatic test_flush();
    bit seen_done;
    seen_done = 1'b0;
    issue(MD_DIV, 32'd1000, 32'd3);
    for (int i = 0; i < 9; i++) begin
      if (bus.done) seen_done = 1'b1;
      tick();
    end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL flush_busy_before: got %b want 1", bus.busy); end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy_after: got %b want 0", bus.busy); end
    for (int i = 0; i < 40; i++) begin
      if (bus.done) seen_done = 1'b1;
      tick();
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_done: got %b want 0", seen_done); end
    checks++; if (bus.hi !== 32'd2) begin errors++; $display("[TB] FAIL flush_hi_kept: got %h want %h", bus.hi, 32'd2); end
    checks++; if (bus.lo !== 32'd14) begin errors++; $display("[TB] FAIL flush_lo_kept: got %h want %h", bus.lo, 32'd14); end
    bus.flush = 1'b1;
    issue(MD_MTHI, 32'h00000055, 32'h0);
    checks++; if (bus.hi !== 32'd2) begin errors++; $display("[TB] FAIL flush_start_hi: got %h want %h", bus.hi, 32'd2); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL flush_start_done: got %b want 0", bus.done); end
    issue(MD_DIV, 32'd9, 32'd3);
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_start_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_undefined();
    issue(3'b111, 32'h000000FF, 32'h1);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL undef_done: got %b want 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL undef_busy: got %b want 0", bus.busy); end
    checks++; if (bus.hi !== 32'd2) begin errors++; $display("[TB] FAIL undef_hi: got %h want %h", bus.hi, 32'd2); end
    checks++; if (bus.lo !== 32'd14) begin errors++; $display("[TB] FAIL undef_lo: got %h want %h", bus.lo, 32'd14); end
  endtask

  task automatic test_move();
    issue(MD_MTHI, 32'hDEADBEEF, 32'h0);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL mthi_done: got %b want 1", bus.done); end
    checks++; if (bus.hi !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL mthi_hi: got %h want %h", bus.hi, 32'hDEADBEEF); end
    checks++; if (bus.lo !== 32'd14) begin errors++; $display("[TB] FAIL mthi_lo_kept: got %h want %h", bus.lo, 32'd14); end
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL mthi_done_pulse: got %b want 0", bus.done); end
    issue(MD_MTLO, 32'h0000CAFE, 32'h0);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL mtlo_done: got %b want 1", bus.done); end
    checks++; if (bus.lo !== 32'h0000CAFE) begin errors++; $display("[TB] FAIL mtlo_lo: got %h want %h", bus.lo, 32'h0000CAFE); end
    checks++; if (bus.hi !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL mtlo_hi_kept: got %h want %h", bus.hi, 32'hDEADBEEF); end
    tick();
  endtask

  task automatic test_reset_mid();
    int nb, nd, da;
    issue(MD_DIV, 32'd50, 32'd5);
    for (int i = 0; i < 4; i++) tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_busy_before: got %b want 1", bus.busy); end
    rst = 1'b1;
    #1;
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_hi: got %h want %h", bus.hi, 32'h0); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_lo: got %h want %h", bus.lo, 32'h0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b want 0", bus.busy); end
    tick();
    rst = 1'b0;
    tick();
    issue(MD_DIVU, 32'd9, 32'd4);
    wait_idle(nb, nd, da);
    checks++; if (bus.lo !== 32'd2) begin errors++; $display("[TB] FAIL post_rst_lo: got %h want %h", bus.lo, 32'd2); end
    checks++; if (bus.hi !== 32'd1) begin errors++; $display("[TB] FAIL post_rst_hi: got %h want %h", bus.hi, 32'd1); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_boundary();
    test_back_to_back();
    test_flush();
    test_undefined();
    test_move();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
